alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 157 +++++++++++++++
 tb/tb_alu_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_pipe : two-stage valid/ready ALU (SUB, NAND, ONES, DEC) with a
//            saturating counter of delivered error beats.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [WIDTH-1:0] i_arg0,
  input  logic [WIDTH-1:0] i_arg1,
  input  logic [1:0]       i_oper,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flag,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam logic [1:0]       OP_SUB  = 2'b00;
  localparam logic [1:0]       OP_NAND = 2'b01;
  localparam logic [1:0]       OP_ONES = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flag_q, flag_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             s1_load;
  logic             s2_load;
  logic             deliver;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c;
  logic             err_c;
  logic             run;
  logic             nz;

  assign s2_load = s1_valid_q & (~s2_valid_q | i_ready);
  assign s1_load = ~s1_valid_q | s2_load;
  assign deliver = s2_valid_q & i_ready;
  assign diff    = s1_a_q - s1_b_q;

  // Execute stage: operates only on registered S1 operands.
  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    err_c = 1'b0;
    run   = 1'b1;
    case (s1_op_q)
      OP_SUB: begin
        res_c = diff;
        ovf_c = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                (diff[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      OP_NAND: begin
        res_c = ~(s1_a_q & s1_b_q);
      end
      OP_ONES: begin
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (run && s1_a_q[i]) begin
            res_c = res_c + 1'b1;
          end else begin
            run = 1'b0;
          end
        end
      end
      default: begin
        if ((s1_a_q != '0) && ((s1_a_q & (s1_a_q - 1'b1)) == '0)) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (s1_a_q[i]) begin
              res_c = WIDTH'(i);
            end
          end
        end else begin
          err_c = 1'b1;
        end
      end
    endcase
    nz = |res_c;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    if (s1_load) begin
      s1_valid_d = i_valid;
      if (i_valid) begin
        s1_a_d  = i_arg0;
        s1_b_d  = i_arg1;
        s1_op_d = i_oper;
      end
    end

    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    flag_d     = flag_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      result_d   = res_c;
      flag_d     = {ovf_c, ~res_c[WIDTH-1] & nz, res_c[WIDTH-1] & nz, err_c};
    end else if (i_ready) begin
      s2_valid_d = 1'b0;
    end

    // Clear wins over a same-edge increment.
    err_cnt_d = err_cnt_q;
    if (i_clr) begin
      err_cnt_d = '0;
    end else if (deliver && flag_q[0] && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      flag_q     <= '0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      flag_q     <= flag_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign o_ready   = s1_load;
  assign o_valid   = s2_valid_q;
  assign o_result  = result_q;
  assign o_flag    = flag_q;
  assign o_err_cnt = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_pipe : directed vector table plus stall, saturation and reset sequences.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_alu_pipe;

  localparam logic [1:0] SUB  = 2'b00;
  localparam logic [1:0] NAND = 2'b01;
  localparam logic [1:0] ONES = 2'b10;
  localparam logic [1:0] DEC  = 2'b11;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flag;
    logic [7:0] cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] arg0, arg1;
  logic [1:0] oper;
  logic       in_valid, out_ready, out_valid, ds_ready, clr;
  logic [7:0] result;
  logic [3:0] flag;
  logic [7:0] err_cnt;

  int   n_pass  = 0;
  int   n_total = 0;
  vec_t vecs[15];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8), .CNT_W(8)) dut (
    .i_clk    (clk),
    .i_rstn   (rstn),
    .i_arg0   (arg0),
    .i_arg1   (arg1),
    .i_oper   (oper),
    .i_valid  (in_valid),
    .o_ready  (out_ready),
    .o_valid  (out_valid),
    .i_ready  (ds_ready),
    .o_result (result),
    .o_flag   (flag),
    .i_clr    (clr),
    .o_err_cnt(err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    oper     = op;
    arg0     = a;
    arg1     = b;
    in_valid = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{SUB,  8'h05, 8'h07, 8'hFE, 4'b0010, 8'd0};
    vecs[1]  = '{SUB,  8'h80, 8'h01, 8'h7F, 4'b1100, 8'd0};
    vecs[2]  = '{NAND, 8'hF0, 8'hFF, 8'h0F, 4'b0100, 8'd0};
    vecs[3]  = '{ONES, 8'hE5, 8'h5A, 8'h03, 4'b0100, 8'd0};
    vecs[4]  = '{ONES, 8'h00, 8'hFF, 8'h00, 4'b0000, 8'd0};
    vecs[5]  = '{DEC,  8'h10, 8'h5A, 8'h04, 4'b0100, 8'd0};
    vecs[6]  = '{DEC,  8'h11, 8'h00, 8'h00, 4'b0001, 8'd1};
    vecs[7]  = '{SUB,  8'h7F, 8'hFF, 8'h80, 4'b1010, 8'd1};
    vecs[8]  = '{NAND, 8'h0F, 8'h0F, 8'hF0, 4'b0010, 8'd1};
    vecs[9]  = '{ONES, 8'hFF, 8'h00, 8'h08, 4'b0100, 8'd1};
    vecs[10] = '{DEC,  8'h80, 8'hFF, 8'h07, 4'b0100, 8'd1};
    vecs[11] = '{DEC,  8'h00, 8'h01, 8'h00, 4'b0001, 8'd2};
    vecs[12] = '{DEC,  8'h01, 8'h00, 8'h00, 4'b0000, 8'd2};
    vecs[13] = '{SUB,  8'h03, 8'h03, 8'h00, 4'b0000, 8'd2};
    vecs[14] = '{ONES, 8'h7F, 8'hFF, 8'h00, 4'b0000, 8'd2};

    rstn = 1'b0; arg0 = '0; arg1 = '0; oper = '0;
    in_valid = 1'b0; ds_ready = 1'b1; clr = 1'b0;
    #1;
    check("rst_o_valid",  out_valid, 0);
    check("rst_o_ready",  out_ready, 1);
    check("rst_o_result", result, 0);
    check("rst_o_flag",   flag, 0);
    check("rst_err_cnt",  err_cnt, 0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_o_ready", out_ready, 1);

    // One beat per vector: accept, S2 load, then delivered on the next edge.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("v%0d_not_yet_valid", i), out_valid, 0);
      @(negedge clk);
      check($sformatf("v%0d_o_valid", i), out_valid, 1);
      check($sformatf("v%0d_o_result", i), result, vecs[i].res);
      check($sformatf("v%0d_o_flag", i), flag, vecs[i].flag);
      @(negedge clk);
      check($sformatf("v%0d_err_cnt", i), err_cnt, vecs[i].cnt);
    end

    // Back-pressure: two beats buffer, third is refused until i_ready rises.
    ds_ready = 1'b0;
    drive(SUB, 8'h05, 8'h07);
    @(negedge clk);
    drive(NAND, 8'hF0, 8'hFF);
    @(negedge clk);
    drive(ONES, 8'hE5, 8'h00);
    #1;
    check("stall_o_ready_low", out_ready, 0);
    check("stall_o_valid",     out_valid, 1);
    check("stall_result_b1",   result, 8'hFE);
    @(negedge clk);
    check("stall_hold_result", result, 8'hFE);
    check("stall_hold_flag",   flag, 4'b0010);
    check("stall_still_low",   out_ready, 0);
    ds_ready = 1'b1;
    #1;
    check("unstall_o_ready", out_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("drain_b2_result", result, 8'h0F);
    check("drain_b2_flag",   flag, 4'b0100);
    @(negedge clk);
    check("drain_b3_valid",  out_valid, 1);
    check("drain_b3_result", result, 8'h03);
    check("drain_b3_flag",   flag, 4'b0100);
    @(negedge clk);
    check("drain_empty", out_valid, 0);
    check("drain_err_cnt", err_cnt, 8'd2);

    // 300 error beats streamed back-to-back; counter must pin at 0xFF.
    drive(DEC, 8'h03, 8'h00);
    for (int i = 0; i < 300; i++) @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("sat_err_cnt", err_cnt, 8'hFF);

    // Clear on the same edge as an error delivery.
    drive(DEC, 8'h03, 8'h00);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_beat_valid", out_valid, 1);
    check("clr_beat_flag",  flag, 4'b0001);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_err_cnt", err_cnt, 8'h00);
    check("clr_delivered", out_valid, 0);

    // Reset with both stages full, asserted between clock edges.
    drive(DEC, 8'h00, 8'h00);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_err_cnt", err_cnt, 8'h01);
    ds_ready = 1'b0;
    drive(DEC, 8'h05, 8'h00);
    @(negedge clk);
    drive(NAND, 8'hF0, 8'hFF);
    @(negedge clk);
    in_valid = 1'b0;
    check("full_o_ready_low", out_ready, 0);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_o_valid",  out_valid, 0);
    check("arst_o_flag",   flag, 0);
    check("arst_o_result", result, 0);
    check("arst_err_cnt",  err_cnt, 0);
    check("arst_o_ready",  out_ready, 1);
    @(negedge clk);
    rstn = 1'b1;
    ds_ready = 1'b1;
    @(negedge clk);
    check("after_rst_no_stale", out_valid, 0);
    drive(SUB, 8'h09, 8'h02);
    @(negedge clk);
    in_valid = 1'b0;
    check("after_rst_latency", out_valid, 0);
    @(negedge clk);
    check("after_rst_valid",  out_valid, 1);
    check("after_rst_result", result, 8'h07);
    check("after_rst_flag",   flag, 4'b0100);
    @(negedge clk);
    check("after_rst_drained", out_valid, 0);
    check("after_rst_err_cnt", err_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
